// File: rtl/lsu_mem_master_if.sv
// Core request/response channel plus word-addressed data-memory port of the load/store master.
// The slave modport is the LSU's view; the master modport is the core/memory side.
interface lsu_mem_master_if #(
    parameter int ADDR = 10,
    parameter int DATA = 32
) ();
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [31:0]     req_addr;
    logic [31:0]     req_wdata;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic            mem_wr_en;
    logic [ADDR-1:0] mem_addr;
    logic [DATA-1:0] mem_d_in;
    logic [DATA-1:0] mem_d_out;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_d_out,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, mem_addr, mem_d_in
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_d_out,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_wr_en, mem_addr, mem_d_in
    );
endinterface

// File: rtl/lsu_mem_master.sv
// RV32 byte-addressed load/store engine over a 1-cycle-read word memory; sub-word stores use RMW.
// Define LSU_MISALIGN_CHK_EN to report misaligned accesses as errors instead of truncating them.
module lsu_mem_master #(
    parameter int ADDR = 10,
    parameter int DATA = 32
) (
    input logic clk,
    input logic rst,
    lsu_mem_master_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_DATA,
        ST_WR,
        ST_RESP
    } state_t;

    state_t state_reg, state_next;

    logic            we_reg;
    logic [2:0]      funct3_reg;
    logic [1:0]      off_reg;
    logic [31:0]     wdata_reg;
    logic [ADDR-1:0] mem_addr_reg;
    logic [DATA-1:0] d_in_reg;
    logic [31:0]     rsp_rdata_reg;
    logic            rsp_err_reg;

    logic            accept;
    logic            illegal;
    logic            req_err;
    logic [1:0]      eff_off;
    logic [DATA-1:0] merged;
    logic [31:0]     shift_b;
    logic [31:0]     shift_h;
    logic [31:0]     load_val;
    logic            unused_addr_bits;

    assign accept           = bus.req_valid && (state_reg == ST_IDLE);
    assign unused_addr_bits = ^bus.req_addr[31:ADDR+2];

    assign illegal = (bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11) ||
                     (bus.req_funct3[2] && bus.req_we);

`ifdef LSU_MISALIGN_CHK_EN
    logic misaligned;
    assign misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'b00));
    assign req_err    = illegal || misaligned;
`else
    assign req_err    = illegal;
`endif

    // Natural alignment is forced here; with the check enabled a misaligned request never uses it.
    always_comb begin
        case (bus.req_funct3[1:0])
            2'd1:    eff_off = {bus.req_addr[1], 1'b0};
            2'd2:    eff_off = 2'b00;
            default: eff_off = bus.req_addr[1:0];
        endcase
    end

    // Byte-lane merge for SB/SH: selected lanes take store data, others pass the read word through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       byte_sel;
            logic [7:0] wbyte;
            always_comb begin
                byte_sel = 1'b1;
                wbyte    = wdata_reg[8*(gi%2) +: 8];
                if (funct3_reg[1:0] == 2'd0) begin
                    byte_sel = (off_reg == 2'(gi));
                    wbyte    = wdata_reg[7:0];
                end else if (funct3_reg[1:0] == 2'd1) begin
                    byte_sel = (off_reg[1] == 1'(gi / 2));
                end
            end
            assign merged[8*gi +: 8] = byte_sel ? wbyte : bus.mem_d_out[8*gi +: 8];
        end
    endgenerate

    assign shift_b = bus.mem_d_out >> {off_reg, 3'b000};
    assign shift_h = bus.mem_d_out >> {off_reg[1], 4'b0000};

    always_comb begin
        case (funct3_reg)
            3'd0:    load_val = {{24{shift_b[7]}}, shift_b[7:0]};
            3'd1:    load_val = {{16{shift_h[15]}}, shift_h[15:0]};
            3'd4:    load_val = {24'd0, shift_b[7:0]};
            3'd5:    load_val = {16'd0, shift_h[15:0]};
            default: load_val = bus.mem_d_out;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = ST_RESP;
                    else if (bus.req_we && (bus.req_funct3[1:0] == 2'd2))
                        state_next = ST_WR;
                    else
                        state_next = ST_RD;
                end
            end
            ST_RD:   state_next = ST_DATA;
            ST_DATA: state_next = we_reg ? ST_WR : ST_RESP;
            ST_WR:   state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg        <= 1'b0;
            funct3_reg    <= 3'd0;
            off_reg       <= 2'd0;
            wdata_reg     <= 32'd0;
            mem_addr_reg  <= '0;
            d_in_reg      <= '0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        we_reg     <= bus.req_we;
                        funct3_reg <= bus.req_funct3;
                        off_reg    <= eff_off;
                        wdata_reg  <= bus.req_wdata;
                        if (req_err) begin
                            rsp_rdata_reg <= 32'd0;
                            rsp_err_reg   <= 1'b1;
                        end else begin
                            mem_addr_reg <= bus.req_addr[ADDR+1:2];
                            if (bus.req_we) d_in_reg <= bus.req_wdata;
                        end
                    end
                end
                ST_DATA: begin
                    if (we_reg) begin
                        d_in_reg <= merged;
                    end else begin
                        rsp_rdata_reg <= load_val;
                        rsp_err_reg   <= 1'b0;
                    end
                end
                ST_WR: begin
                    rsp_rdata_reg <= 32'd0;
                    rsp_err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Reset gates the write strobe so an in-flight store is never committed on the reset edge.
    assign bus.req_ready = (state_reg == ST_IDLE);
    assign bus.rsp_valid = (state_reg == ST_RESP) && !rst;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.mem_wr_en = (state_reg == ST_WR) && !rst;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_d_in  = d_in_reg;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed plan cases, mid-write reset, then random traffic
// checked against an arithmetic model of RV32 load/store semantics.
module tb_lsu_mem_master;
    localparam int ADDR  = 10;
    localparam int WORDS = 1 << ADDR;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR(ADDR), .DATA(32)) bus ();
    lsu_mem_master #(.ADDR(ADDR), .DATA(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Memory environment: 1-cycle synchronous read, d_out updates only on non-write cycles.
    logic [31:0] mem     [0:WORDS-1];
    logic [31:0] ref_mem [0:WORDS-1];
    int          wr_count = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_d_in;
            wr_count          <= wr_count + 1;
            last_wr_addr      <= 32'(bus.mem_addr);
            last_wr_data      <= bus.mem_d_in;
        end else begin
            bus.mem_d_out <= mem[bus.mem_addr];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: RV32 semantics computed directly on a word array.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                         output int lat, output int nwr, output int widx, output logic [31:0] wword);
        int          nbytes;
        logic        mis;
        logic [31:0] a, w, v;
        int          off;
        nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        mis    = (addr % nbytes) != 0;
        err    = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
`ifdef LSU_MISALIGN_CHK_EN
        err = err || mis;
`endif
        a     = addr - (addr % nbytes);
        widx  = (a / 4) % WORDS;
        off   = a % 4;
        rdata = 32'd0;
        nwr   = 0;
        wword = 32'd0;
        lat   = 1;
        if (!err) begin
            w = ref_mem[widx];
            if (!we) begin
                lat = 3;
                v   = w >> (8 * off);
                if (nbytes == 1) begin
                    v = v & 32'hFF;
                    if (f3 == 0 && v >= 32'h80) v = v | 32'hFFFFFF00;
                end else if (nbytes == 2) begin
                    v = v & 32'hFFFF;
                    if (f3 == 1 && v >= 32'h8000) v = v | 32'hFFFF0000;
                end
                rdata = v;
            end else begin
                lat = (nbytes == 4) ? 2 : 4;
                nwr = 1;
                for (int i = 0; i < nbytes; i++) begin
                    w[8*(off+i) +: 8] = wdata[8*i +: 8];
                end
                wword          = w;
                ref_mem[widx]  = w;
            end
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata_o, output logic err_o);
        logic        e_err;
        logic [31:0] e_rdata, e_wword;
        int          e_lat, e_nwr, e_widx, lat, wc0;
        model(we, f3, addr, wdata, e_err, e_rdata, e_lat, e_nwr, e_widx, e_wword);
        @(negedge clk);
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        chk("rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        wc0            = wr_count;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        rdata_o = bus.rsp_rdata;
        err_o   = bus.rsp_err;
        $display("req we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 we, f3, addr, wdata, bus.rsp_rdata, bus.rsp_err, lat);
        chk("latency", 32'(lat), 32'(e_lat));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e_err));
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("write_count", 32'(wr_count - wc0), 32'(e_nwr));
        if (e_nwr != 0) begin
            chk("write_addr", last_wr_addr, 32'(e_widx));
            chk("write_data", last_wr_data, e_wword);
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          n, wc_rst, stray, diff;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB; ref_mem[4] = 32'h8899AABB;
        mem[5] = 32'h11223344; ref_mem[5] = 32'h11223344;
        mem[6] = 32'h0BADF00D; ref_mem[6] = 32'h0BADF00D;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(bus.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_err", 32'(bus.rsp_err), 32'd0);
        chk("reset_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("reset_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("reset_d_in", bus.mem_d_in, 32'd0);

        do_req(1'b0, 3'd0, 32'h11, 32'd0, rd, er); chk("lb_11", rd, 32'hFFFFFFAA);
        do_req(1'b0, 3'd4, 32'h13, 32'd0, rd, er); chk("lbu_13", rd, 32'h00000088);
        do_req(1'b0, 3'd5, 32'h12, 32'd0, rd, er); chk("lhu_12", rd, 32'h00008899);
        do_req(1'b0, 3'd1, 32'h10, 32'd0, rd, er); chk("lh_10", rd, 32'hFFFFAABB);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, rd, er); chk("lw_10", rd, 32'h8899AABB);
        do_req(1'b1, 3'd0, 32'h15, 32'hDEADBEEF, rd, er); chk("sb_15_data", last_wr_data, 32'h1122EF44);
        do_req(1'b0, 3'd2, 32'h14, 32'd0, rd, er); chk("lw_14", rd, 32'h1122EF44);
        do_req(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, rd, er); chk("sw_20_addr", last_wr_addr, 32'd8);
        do_req(1'b1, 3'd1, 32'h22, 32'h00001234, rd, er);
        do_req(1'b0, 3'd2, 32'h20, 32'd0, rd, er); chk("lw_20", rd, 32'h1234F00D);
        do_req(1'b0, 3'd3, 32'h20, 32'd0, rd, er); chk("f3_3_err", 32'(er), 32'd1);
        do_req(1'b1, 3'd4, 32'h20, 32'h55, rd, er); chk("sbu_err", 32'(er), 32'd1);
        do_req(1'b0, 3'd2, 32'h21, 32'd0, rd, er);
        do_req(1'b1, 3'd1, 32'h23, 32'hABCD, rd, er);
        do_req(1'b0, 3'd2, 32'hFFFFF010, 32'd0, rd, er); chk("lw_wrap", rd, 32'h8899AABB);

        // Reset while an SB to word 6 sits in its write cycle.
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h18;
        bus.req_wdata  = 32'h00000055;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 0;
        while (!bus.mem_wr_en && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("rst_wr_reached", 32'(n < 8), 32'd1);
        wc_rst = wr_count;
        rst = 1'b1;
        #1;
        chk("rst_wr_gated", 32'(bus.mem_wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready_after", 32'(bus.req_ready), 32'd1);
        stray = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid) stray++;
            @(negedge clk);
        end
        chk("rst_no_rsp", 32'(stray), 32'd0);
        chk("rst_no_write", 32'(wr_count - wc_rst), 32'd0);
        chk("rst_mem6", mem[6], 32'h0BADF00D);

        for (int t = 0; t < 200; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd, er);
        end

        @(negedge clk);
        diff = 0;
        for (int i = 0; i < WORDS; i++) begin
            if (mem[i] !== ref_mem[i]) diff++;
        end
        chk("final_mem_diff", 32'(diff), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Core-side load/store initiator that drives the word-addressed, single-port data memory.
- Memory contract:
  - 1-cycle synchronous read.
  - No byte enables.
  - `d_out` updates only on non-write cycles.
- Converts byte-addressed RV32 loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into memory cycles.
- Sub-word stores use read-modify-write. Load data is sign/zero-extended.

Parameters:
- ADDR, 10, memory word-address width (memory holds 2**ADDR words).
- DATA, 32, memory word width; only 32 is supported.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- req_valid  input  1  core request valid
- req_ready  output  1  block can accept a request
- req_we  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32 funct3: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low byte/half used for SB/SH
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores/errors
- rsp_err  output  1  misaligned or illegal funct3, valid with rsp_valid
- mem_wr_en  output  1  memory write enable
- mem_addr  output  ADDR  memory word address = req_addr[ADDR+1:2] latched
- mem_d_in  output  DATA  memory write data
- mem_d_out  input  DATA  memory read data, valid the cycle after a non-write cycle

Behaviour:
- Reset: state IDLE, all latched request fields cleared.
  - req_ready=1 in IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_wr_en=0, mem_addr=0, mem_d_in=0.
- mem_wr_en is gated combinationally with ~rst, so a write in flight is never committed on a reset edge.
- Accept: req_valid & req_ready in IDLE. Latch we, funct3, addr, wdata. req_ready=0 in every other state.
- States and transitions:
  - IDLE:
    - Illegal funct3 (3, 6, 7; or 4/5 with we=1) or misaligned -> RESP with err.
    - SW -> WR.
    - Any load or SB/SH -> RD.
  - RD: mem_wr_en=0, mem_addr driven -> DATA.
  - DATA: mem_d_out valid.
    - Load: extract lane, register result -> RESP.
    - SB/SH: merge new lane into mem_d_out word, register -> WR.
  - WR: mem_wr_en=1, mem_d_in = merged word (SW: full req_wdata) -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle -> IDLE. There is no response backpressure.
- Latency (accept edge to rsp_valid cycle): error 1, SW 2, load 3, SB/SH 4.
- Back-to-back issue: next request is accepted the cycle after RESP (req_ready high in IDLE).
- Alignment rules:
  - LH/LHU/SH require addr[0]=0.
  - LW/SW require addr[1:0]=0.
  - LB/LBU/SB are always aligned.
- Lane select is little-endian.
  - Byte lane k = addr[1:0] selects bits [8k+7:8k].
  - Half lane = addr[1] selects bits [16·addr[1]+15 : 16·addr[1]].
- Extension: LB/LH sign-extend; LBU/LHU zero-extend.
- RMW merge: unselected bytes come unchanged from mem_d_out.
- Address: bits above ADDR+1 are ignored (silent wrap). Bits [1:0] never reach memory.
- rsp_rdata/rsp_err hold their last values outside rsp_valid; the bench checks them only when rsp_valid=1.
- mem_addr holds its last value in IDLE. mem_wr_en=0 in all states except WR.
- Reset asserted in any state: next edge goes to IDLE. No write occurs, no response is produced, and the pending request is dropped.

Optional Feature:
- Macro: LSU_MISALIGN_CHK_EN.
- Defined: misaligned accesses produce rsp_err=1 with zero memory cycles (mem_wr_en never asserts).
- Undefined:
  - No alignment check; addr[0] for halves and addr[1:0] for words are treated as 0 (access truncated to natural alignment).
  - Illegal funct3 is still an error.

Test Plan:
- mem[4]=0x8899AABB; LB addr 0x11 -> after 3 cycles rsp_rdata=0xFFFFFFAA, rsp_err=0; LBU 0x13 -> 0x00000088.
- mem[4]=0x8899AABB; LHU 0x12 -> 0x00008899; LH 0x10 -> 0xFFFFAABB; LW 0x10 -> 0x8899AABB.
- mem[5]=0x11223344; SB addr 0x15 wdata 0xDEADBEEF -> one mem_wr_en pulse, mem_d_in=0x1122EF44, rsp_valid 4 cycles after accept; then LW 0x14 -> 0x1122EF44.
- SW 0x20 wdata 0xCAFEF00D -> mem_wr_en in cycle 1 with mem_addr=8, rsp_valid in cycle 2; SH 0x22 wdata 0x1234 -> mem[8]=0x1234F00D.
- With LSU_MISALIGN_CHK_EN: LW 0x21 -> rsp_err=1 next cycle, no mem_wr_en; SH 0x23 -> rsp_err=1, memory unchanged. funct3=3 -> rsp_err=1 (either build).
- Assert rst during WR of SB to mem[6] -> mem[6] unchanged, no rsp_valid, req_ready=1 the cycle after reset deasserts.
